// File: rtl/geo_cmd_bridge.sv
// geo_cmd_bridge: pairs Z80 byte writes into 16-bit geometry commands,
// buffers them in a small register FIFO and drains one word per cycle
// into the geometry processor whenever it is not signalling busy.
module geo_cmd_bridge #(
  parameter int DEPTH       = 16,
  parameter int BUSY_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_hi_strobe,
  input  logic                       wr_lo_strobe,
  input  logic [7:0]                 wr_data,
  input  logic                       flush,
  input  logic                       overflow_clr,
  input  logic                       fifo_cmd_busy,
  output logic                       fifo_cmd_ready,
  output logic [15:0]                fifo_cmd_in,
  output logic [$clog2(DEPTH):0]     cmd_level,
  output logic                       cmd_full,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_MAX  = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH - BUSY_MARGIN);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    hi_q;
  logic          ovf_q;

  // Output stage registers: the delivered word and its strobe.
  logic          vld_p1;
  logic [15:0]   word_p1;

  logic          pop;
  logic          push_req;
  logic          push;
  logic          drop;
  logic          at_max;

  // Handshake decode. A push into a full FIFO survives only if a pop frees
  // the head slot on the same edge; flush swallows any push silently.
  always_comb begin
    at_max   = (level == LEVEL_MAX);
    pop      = (level != '0) && !fifo_cmd_busy && !flush;
    push_req = wr_lo_strobe && !flush;
    push     = push_req && (!at_max || pop);
    drop     = push_req && at_max && !pop;
  end

  // Word storage, deliberately left unreset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {hi_q, wr_data};
    end
  end

  // Pointers and level counter; level is tracked separately from pointers
  // so full and empty are unambiguous when the pointers coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // High-byte latch; a same-cycle low strobe has already used the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
    end else if (flush) begin
      hi_q <= '0;
    end else if (wr_hi_strobe) begin
      hi_q <= wr_data;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (overflow_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // ---- stage p1: registered delivery to the geometry processor ----
  // Strobe for one cycle per popped word; the word holds between pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) word_p1 <= mem[rd_ptr];
    end
  end

  assign fifo_cmd_ready = vld_p1;
  assign fifo_cmd_in    = word_p1;
  assign cmd_level      = level;
  assign cmd_full       = (level >= LEVEL_FULL);
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_geo_cmd_bridge.sv
// Self-checking bench for geo_cmd_bridge: directed phases plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_geo_cmd_bridge;

  localparam int DEPTH       = 16;
  localparam int BUSY_MARGIN = 4;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_hi_strobe = 1'b0;
  logic          wr_lo_strobe = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          flush = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          fifo_cmd_busy = 1'b0;
  logic          fifo_cmd_ready;
  logic [15:0]   fifo_cmd_in;
  logic [LW-1:0] cmd_level;
  logic          cmd_full;
  logic          overflow;

  always #5 clk = ~clk;

  geo_cmd_bridge #(.DEPTH(DEPTH), .BUSY_MARGIN(BUSY_MARGIN)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_hi_strobe   (wr_hi_strobe),
    .wr_lo_strobe   (wr_lo_strobe),
    .wr_data        (wr_data),
    .flush          (flush),
    .overflow_clr   (overflow_clr),
    .fifo_cmd_busy  (fifo_cmd_busy),
    .fifo_cmd_ready (fifo_cmd_ready),
    .fifo_cmd_in    (fifo_cmd_in),
    .cmd_level      (cmd_level),
    .cmd_full       (cmd_full),
    .overflow       (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: queue contents, latched high byte, flags.
  logic [15:0] q[$];
  logic [15:0] acc[$];
  logic [15:0] seen[$];
  logic [7:0]  m_hi  = '0;
  logic        m_ovf = 1'b0;
  logic        m_rdy = 1'b0;
  logic [15:0] m_in  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hi  = '0;
    m_ovf = 1'b0;
    m_rdy = 1'b0;
    m_in  = '0;
  endtask

  task automatic check_all();
    chk("ready",    {31'd0, fifo_cmd_ready}, {31'd0, m_rdy});
    chk("cmd_in",   {16'd0, fifo_cmd_in},    {16'd0, m_in});
    chk("level",    32'(cmd_level),          32'(q.size()));
    chk("full",     {31'd0, cmd_full},       {31'd0, (q.size() >= DEPTH - BUSY_MARGIN)});
    chk("overflow", {31'd0, overflow},       {31'd0, m_ovf});
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check.
  task automatic step(input bit hi, input bit lo, input logic [7:0] d,
                      input bit fl, input bit clr, input bit busy);
    bit pop;
    bit drop;
    wr_hi_strobe  = hi;
    wr_lo_strobe  = lo;
    wr_data       = d;
    flush         = fl;
    overflow_clr  = clr;
    fifo_cmd_busy = busy;
    @(posedge clk);
    pop  = (q.size() != 0) && !busy && !fl;
    drop = 1'b0;
    m_rdy = pop;
    if (pop) m_in = q[0];
    if (fl) begin
      q.delete();
      m_hi = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (lo) begin
        if (q.size() < DEPTH) begin
          q.push_back({m_hi, d});
          acc.push_back({m_hi, d});
        end else begin
          drop = 1'b1;
        end
      end
      if (hi) m_hi = d;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check_all();
    if (fifo_cmd_ready) seen.push_back(fifo_cmd_in);
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, busy);
  endtask

  initial begin
    int pushes;
    int c;
    // Reset state
    #1;
    chk("rst_ready", {31'd0, fifo_cmd_ready}, 32'd0);
    chk("rst_in",    {16'd0, fifo_cmd_in},    32'd0);
    chk("rst_level", 32'(cmd_level),          32'd0);
    chk("rst_full",  {31'd0, cmd_full},       32'd0);
    chk("rst_ovf",   {31'd0, overflow},       32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    // Basic word
    seen.delete();
    step(1, 0, 8'hA5, 0, 0, 0);
    step(0, 1, 8'h3C, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("basic_ready", {31'd0, fifo_cmd_ready}, 32'd1);
    chk("basic_word",  {16'd0, fifo_cmd_in},    32'h0000A53C);
    idle(3, 0);
    chk("basic_count", 32'(seen.size()), 32'd1);
    chk("basic_level", 32'(cmd_level),   32'd0);

    // Latched high byte and simultaneous strobes
    seen.delete();
    step(1, 0, 8'h12, 0, 0, 0);
    step(0, 1, 8'h01, 0, 0, 0);
    step(0, 1, 8'h02, 0, 0, 0);
    step(1, 1, 8'h77, 0, 0, 0);
    idle(4, 0);
    chk("latch_count", 32'(seen.size()), 32'd3);
    chk("latch_w0", {16'd0, seen[0]}, 32'h00001201);
    chk("latch_w1", {16'd0, seen[1]}, 32'h00001202);
    chk("latch_w2", {16'd0, seen[2]}, 32'h00001277);

    // Back-pressure and fill: 20 pushes into 16 slots
    for (int i = 0; i < 20; i++) step(0, 1, 8'(i), 0, 0, 1);
    chk("fill_level", 32'(cmd_level), 32'd16);
    chk("fill_ovf",   {31'd0, overflow}, 32'd1);
    seen.delete();
    idle(16, 0);
    chk("drain_count", 32'(seen.size()), 32'd16);
    chk("drain_first", {16'd0, seen[0]},  32'h00007700);
    chk("drain_last",  {16'd0, seen[15]}, 32'h0000770F);
    idle(2, 0);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 1);
    step(0, 1, 8'hEE, 0, 0, 0);
    chk("fullpp_level", 32'(cmd_level),   32'd16);
    chk("fullpp_ovf",   {31'd0, overflow}, 32'd0);
    idle(18, 0);

    // Flush with 5 queued and a push in the flush cycle
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h90 + i), 0, 0, 1);
    step(0, 1, 8'h55, 1, 0, 0);
    chk("flush_level", 32'(cmd_level), 32'd0);
    chk("flush_ovf",   {31'd0, overflow}, 32'd0);
    seen.delete();
    idle(3, 0);
    chk("flush_quiet", 32'(seen.size()), 32'd0);
    step(0, 1, 8'h09, 0, 0, 0);
    idle(3, 0);
    chk("flush_after", {16'd0, seen[0]}, 32'h00000009);

    // Wrap: 40 random words, busy toggling every 3 cycles
    seen.delete();
    acc.delete();
    pushes = 0;
    c = 0;
    while (pushes < 40 && c < 400) begin
      if (c % 2 == 0) begin
        step(bit'($urandom_range(0, 1)), 1, 8'($urandom), 0, 0, bit'((c / 3) % 2));
        pushes++;
      end else begin
        step(0, 0, 8'($urandom), 0, 0, bit'((c / 3) % 2));
      end
      c++;
    end
    idle(DEPTH + 4, 0);
    chk("wrap_count", 32'(seen.size()), 32'(acc.size()));
    for (int i = 0; i < acc.size(); i++) chk("wrap_order", {16'd0, seen[i]}, {16'd0, acc[i]});

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), 8'($urandom),
           bit'($urandom_range(0, 31) == 0), bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 2) == 0));
    end
    idle(DEPTH + 4, 0);

    // Reset mid-stream
    step(1, 1, 8'h5A, 0, 0, 0);
    step(0, 1, 8'hC3, 0, 0, 0);
    step(0, 1, 8'h3C, 0, 0, 0);
    chk("pre_rst_ready", {31'd0, fifo_cmd_ready}, 32'd1);
    reset = 1'b0;
    wr_hi_strobe = 1'b0;
    wr_lo_strobe = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, fifo_cmd_ready}, 32'd0);
    chk("mid_rst_in",    {16'd0, fifo_cmd_in},    32'd0);
    chk("mid_rst_level", 32'(cmd_level),          32'd0);
    chk("mid_rst_full",  {31'd0, cmd_full},       32'd0);
    chk("mid_rst_ovf",   {31'd0, overflow},       32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    idle(3, 0);
    step(0, 1, 8'h21, 0, 0, 0);
    idle(2, 0);
    chk("post_rst_word", {16'd0, fifo_cmd_in}, 32'h00000021);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/geo_cmd_bridge.md
# geo_cmd_bridge

Byte-to-word command bridge between the Z80 bus interface and the geometry processor. It assembles pairs of Z80 byte writes (high byte, then low byte) into 16-bit geometry commands and buffers them in a small local FIFO. It drains the FIFO into the geometry processor's `fifo_cmd_ready` / `fifo_cmd_in` input, throttled by that block's `fifo_cmd_busy`. It gives the Z80 a fill level, an almost-full flag and a sticky overflow flag for polling.

## Interface
- `DEPTH`, 16: local FIFO depth in words; power of 2, at least 4.
- `BUSY_MARGIN`, 4: free slots remaining when `cmd_full` asserts; must be less than `DEPTH`.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  reset, asynchronous, active-low.
- `wr_hi_strobe`  input  1  one-cycle pulse; `wr_data` is the command high byte.
- `wr_lo_strobe`  input  1  one-cycle pulse; `wr_data` is the command low byte; completes and pushes a word.
- `wr_data`  input  8  Z80 write data.
- `flush`  input  1  one-cycle pulse; empties the FIFO and clears the high-byte latch.
- `overflow_clr`  input  1  one-cycle pulse; clears `overflow`.
- `fifo_cmd_busy`  input  1  back-pressure from the geometry processor.
- `fifo_cmd_ready`  output  1  one-cycle strobe per word delivered.
- `fifo_cmd_in`  output  16  command word; valid while `fifo_cmd_ready` is high.
- `cmd_level`  output  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- `cmd_full`  output  1  high when `cmd_level >= DEPTH-BUSY_MARGIN`.
- `overflow`  output  1  sticky; high after any word is dropped.

## Operation
- **High-byte latch** `hi_q[7:0]`
  - Loaded on `wr_hi_strobe`.
  - Keeps its value across pushes, so repeated low-byte writes reuse the same high byte.
- **Push**
  - On `wr_lo_strobe`, the word `{hi_q, wr_data}` is pushed.
  - If both strobes are high in the same cycle, the push uses the old `hi_q`, then `hi_q` loads `wr_data`.
- **FIFO**
  - Register array of `DEPTH` words, with write and read pointers each `$clog2(DEPTH)` bits wide.
  - Pointers wrap modulo `DEPTH` with no special case.
  - The head word is read combinationally from the read pointer.
  - `cmd_level` is a separate counter, not derived from the pointers.
- **Push when full**
  - If `cmd_level==DEPTH` and no pop happens that cycle: the word is dropped, the pointers and level are unchanged, and `overflow` is set.
  - If a pop happens in the same cycle: the push is accepted and `cmd_level` stays at DEPTH.
- **Pop**
  - Condition, evaluated each cycle: `cmd_level!=0 && !fifo_cmd_busy && !flush`.
  - When true: `fifo_cmd_in` is registered from the head word, `fifo_cmd_ready` is registered high, and the read pointer advances.
  - Otherwise `fifo_cmd_ready` is registered low and `fifo_cmd_in` holds its last value.
- **Level counter**
  - Push only: +1. Pop only: −1. Both or neither: unchanged.
  - It never goes below 0 or above DEPTH.
- **Drain rate**
  - At most one word per cycle while `fifo_cmd_busy` is low.
  - The geometry processor's FIFO margin absorbs the one-cycle lag between busy and pop.
- **Flush**
  - Clears both pointers, `cmd_level` and `hi_q`.
  - A push arriving in the same cycle is discarded and does not set `overflow`.
  - `overflow` is unaffected.
  - `fifo_cmd_ready` is 0 in the following cycle.
- **Overflow clear**
  - If `overflow_clr` and a drop happen in the same cycle, set wins and `overflow` stays 1.
- **Derived flags**
  - `cmd_full` is a combinational compare on the registered `cmd_level`.

## Timing
- **Reset** (asserted asynchronously, released synchronously in the system):
  - `fifo_cmd_ready`=0, `fifo_cmd_in`=16'h0000, `cmd_level`=0, `cmd_full`=0, `overflow`=0.
  - `hi_q`=0 and both pointers =0.
  - FIFO contents are not reset.
- **Reset mid-operation:** queued words are lost and no partial strobe is emitted.
- **Latency:** with `wr_lo_strobe` in cycle N and `fifo_cmd_busy` low, `fifo_cmd_ready` is high in cycle N+2 carrying that word.
- **Back-pressure:** if `fifo_cmd_busy` is high in cycle N, `fifo_cmd_ready` is low in N+1.
- **Ordering:** strict FIFO order, with no duplication and no reordering.
- **`cmd_level`:** updates on the edge that ends the push or pop cycle.

## Test plan
- **Basic word:** after reset, `wr_hi_strobe` with 8'hA5, then `wr_lo_strobe` with 8'h3C, busy low -> exactly one `fifo_cmd_ready` pulse 2 cycles after the low strobe, with `fifo_cmd_in`=16'hA53C; `cmd_level` returns to 0.
- **Latched high byte and simultaneous strobes:**
  - High byte 8'h12, then low bytes 8'h01 and 8'h02 -> words 16'h1201 and 16'h1202.
  - Then both strobes in the same cycle with `wr_data`=8'h77 -> word 16'h1277, and `hi_q` becomes 8'h77.
- **Back-pressure and fill:** hold busy high, push 20 words with DEPTH=16 ->
  - `cmd_full` rises when `cmd_level` reaches 12.
  - `cmd_level` saturates at 16 and `overflow`=1.
  - Releasing busy -> the first 16 words come out in order on 16 consecutive cycles.
- **Full with simultaneous push and pop:** level 16, busy low, push in the same cycle as the pop -> word accepted, `overflow` stays 0, `cmd_level` stays 16.
- **Flush:** with 5 words queued plus a push in the flush cycle ->
  - `cmd_level`=0 next cycle and no further `fifo_cmd_ready` pulses.
  - `overflow` unchanged.
  - A subsequent low-byte write of 8'h09 yields 16'h0009.
- **Wrap and reset:**
  - Stream 40 words with busy toggling every 3 cycles -> output sequence equals input sequence across pointer wrap.
  - Assert `reset` low mid-stream -> all outputs 0 immediately.
